// File: rtl/sram22_sp_ram_pkg.sv
// Shared types and helpers for the sram22 single-port RAM model.
// Latency/backpressure: none (package only).
package sram22_pkg;

  typedef enum logic {INIT, RUN} sram22_state_e;

  // Upper bounds for the generic lane merge; callers zero-extend into these.
  localparam int SRAM22_MAX_DW      = 1024;
  localparam int SRAM22_MAX_LANES   = 128;
  localparam int SRAM22_LANE_IDX_W  = $clog2(SRAM22_MAX_LANES);

  function automatic logic [SRAM22_MAX_DW-1:0] sram22_lane_merge(
    input logic [SRAM22_MAX_DW-1:0]    old_w,
    input logic [SRAM22_MAX_DW-1:0]    new_w,
    input logic [SRAM22_MAX_LANES-1:0] mask,
    input int                          lane_w
  );
    logic [SRAM22_MAX_DW-1:0] r;
    int lane;
    r = old_w;
    for (int i = 0; i < SRAM22_MAX_DW; i++) begin
      lane = i / lane_w;
      if (lane < SRAM22_MAX_LANES && mask[lane[SRAM22_LANE_IDX_W-1:0]]) begin
        r[i] = new_w[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sram22_sp_ram_if.sv
// Request/response bundle for sram22_sp_ram: master issues en/we/addr, slave returns data.
// Backpressure: master may only count a request as taken when en && ready.
interface sram22_sp_ram_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WMASK_WIDTH = 4
);
  logic                   ready;
  logic                   en;
  logic                   we;
  logic [WMASK_WIDTH-1:0] wmask;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  din;
  logic [DATA_WIDTH-1:0]  dout;
  logic                   dout_valid;

  modport master (
    input  ready, dout, dout_valid,
    output en, we, wmask, addr, din
  );

  modport slave (
    output ready, dout, dout_valid,
    input  en, we, wmask, addr, din
  );
endinterface

// File: rtl/sram22_init_seq.sv
// Post-reset clear sequencer: sweeps addresses 0..RAM_DEPTH-1 with zero writes, then raises ready.
// Latency: ready rises RAM_DEPTH cycles after reset release; no backpressure input.
module sram22_init_seq
  import sram22_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_we,
  output logic                  ready
);
  // One extra bit so the terminal count never wraps back to zero.
  localparam int CNT_W = ADDR_WIDTH + 1;

  sram22_state_e    state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= INIT;
      cnt    <= '0;
      clr_we <= 1'b1;
      ready  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(RAM_DEPTH - 1)) begin
            state  <= RUN;
            clr_we <= 1'b0;
            ready  <= 1'b1;
          end
        end
        RUN: begin
          clr_we <= 1'b0;
          ready  <= 1'b1;
        end
      endcase
    end
  end

  assign clr_addr = cnt[ADDR_WIDTH-1:0];

endmodule

// File: rtl/sram22_sp_ram.sv
// Parametrised sram22 single-port RAM model with lane masks and post-reset clear; SRAM22_WRITE_THROUGH_EN makes writes return the merged word.
// Latency 1 (OUT_REG=0) or 2 (OUT_REG=1) cycles, one request per cycle; ready low only during the clear sweep.
module sram22_sp_ram
  import sram22_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WMASK_WIDTH = 4,
  parameter int RAM_DEPTH   = 1 << ADDR_WIDTH,
  parameter int OUT_REG     = 0
) (
  input  logic              clk,
  input  logic              rst,
  sram22_sp_ram_if.slave    bus
);
  localparam int LANE = DATA_WIDTH / WMASK_WIDTH;

`ifdef SRAM22_WRITE_THROUGH_EN
  localparam bit WRITE_THROUGH = 1'b1;
`else
  localparam bit WRITE_THROUGH = 1'b0;
`endif

  if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
    $fatal(1, "sram22_sp_ram: DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end
  if (OUT_REG != 0 && OUT_REG != 1) begin : g_bad_outreg
    $fatal(1, "sram22_sp_ram: OUT_REG must be 0 or 1");
  end
  if (DATA_WIDTH > SRAM22_MAX_DW || WMASK_WIDTH > SRAM22_MAX_LANES) begin : g_too_wide
    $fatal(1, "sram22_sp_ram: width exceeds sram22_pkg merge limits");
  end

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_we;
  logic                  ready;

  sram22_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_DEPTH  (RAM_DEPTH)
  ) u_init_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_addr (clr_addr),
    .clr_we   (clr_we),
    .ready    (ready)
  );

  assign bus.ready = ready;

  logic                  acc;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged;
  logic                  res_vld;
  logic [DATA_WIDTH-1:0] res_dat;

  // A request coinciding with rst is dropped so nothing lands after the reset edge.
  assign acc     = bus.en && ready && !rst;
  assign rd_word = mem[bus.addr];
  assign merged  = DATA_WIDTH'(sram22_lane_merge(SRAM22_MAX_DW'(rd_word),
                                                 SRAM22_MAX_DW'(bus.din),
                                                 SRAM22_MAX_LANES'(bus.wmask),
                                                 LANE));
  assign res_vld = acc && (!bus.we || WRITE_THROUGH);
  assign res_dat = bus.we ? merged : rd_word;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (acc && bus.we) begin
      mem[bus.addr] <= merged;
    end
  end

  logic                  s1_vld;
  logic [DATA_WIDTH-1:0] s1_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= res_vld;
      if (res_vld) s1_dat <= res_dat;
    end
  end

  if (OUT_REG == 1) begin : g_out_reg
    logic                  s2_vld;
    logic [DATA_WIDTH-1:0] s2_dat;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_vld <= 1'b0;
        s2_dat <= '0;
      end else begin
        s2_vld <= s1_vld;
        if (s1_vld) s2_dat <= s1_dat;
      end
    end

    assign bus.dout       = s2_dat;
    assign bus.dout_valid = s2_vld;
  end else begin : g_no_out_reg
    assign bus.dout       = s1_dat;
    assign bus.dout_valid = s1_vld;
  end

endmodule

// File: tb/tb_sram22_sp_ram.sv
// Table-driven bench for sram22_sp_ram with a response scoreboard and hand-written reset/latency sequences.
module tb_sram22_sp_ram;
  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int MW    = 4;
  localparam int DEPTH = 512;
  localparam int OREG  = 0;
  localparam int LAT   = 1 + OREG;
`ifdef SRAM22_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram22_sp_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) bus ();

  sram22_sp_ram #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .WMASK_WIDTH (MW),
    .RAM_DEPTH   (DEPTH),
    .OUT_REG     (OREG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [3:0]  wmask;
    logic [8:0]  addr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt [16];
  logic [31:0] model [DEPTH];
  logic [31:0] sb [$];
  logic [31:0] last_dat = 32'h0;
  int          vectors = 0;
  int          miscompares = 0;
  int          run_len = 0;
  int          max_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.dout_valid === 1'b1) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (sb.size() == 0) begin
        check("spurious_valid", 32'(bus.dout_valid), 32'd0);
      end else begin
        last_dat = sb.pop_front();
        check("rd_data", bus.dout, last_dat);
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic req(input logic w, input logic [3:0] m, input logic [8:0] a,
                     input logic [31:0] d, input logic [31:0] exp);
    logic [31:0] mw;
    bus.en = 1'b1; bus.we = w; bus.wmask = m; bus.addr = a; bus.din = d;
    if (w) begin
      mw = model[a];
      for (int k = 0; k < 4; k++) if (m[k]) mw[k*8 +: 8] = d[k*8 +: 8];
      model[a] = mw;
      if (WT) sb.push_back(mw);
    end else begin
      sb.push_back(exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int start, output int lowc);
    lowc = start;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        bus.en = 1'b0;
        break;
      end
      lowc++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] prev;

    vt[0]  = '{1'b0, 4'h0, 9'h000, 32'h0,        32'h0};
    vt[1]  = '{1'b0, 4'h0, 9'h1A5, 32'h0,        32'h0};
    vt[2]  = '{1'b0, 4'h0, 9'h1FF, 32'h0,        32'h0};
    vt[3]  = '{1'b0, 4'h0, 9'h064, 32'h0,        32'h0};
    vt[4]  = '{1'b1, 4'hF, 9'h1A5, 32'hDEADBEEF, 32'h0};
    vt[5]  = '{1'b1, 4'h5, 9'h1A5, 32'h11223344, 32'h0};
    vt[6]  = '{1'b0, 4'h0, 9'h1A5, 32'h0,        32'hDE22BE44};
    vt[7]  = '{1'b1, 4'hF, 9'h010, 32'h12345678, 32'h0};
    vt[8]  = '{1'b1, 4'h1, 9'h010, 32'h000000AB, 32'h0};
    vt[9]  = '{1'b0, 4'h0, 9'h010, 32'h0,        32'h123456AB};
    vt[10] = '{1'b1, 4'h0, 9'h020, 32'hFFFFFFFF, 32'h0};
    vt[11] = '{1'b0, 4'h0, 9'h020, 32'h0,        32'h0};
    vt[12] = '{1'b1, 4'hF, 9'h1FF, 32'hA5A5A5A5, 32'h0};
    vt[13] = '{1'b0, 4'h0, 9'h1FF, 32'h0,        32'hA5A5A5A5};
    vt[14] = '{1'b1, 4'h8, 9'h030, 32'hCAFEF00D, 32'h0};
    vt[15] = '{1'b0, 4'h0, 9'h030, 32'h0,        32'hCA000000};
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

    bus.en = 1'b0; bus.we = 1'b0; bus.wmask = '0; bus.addr = '0; bus.din = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_dout", bus.dout, 32'h0);
    check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    @(posedge clk); #1;

    // Writes of all-ones held during the clear sweep must be ignored.
    bus.en = 1'b1; bus.we = 1'b1; bus.wmask = 4'hF; bus.addr = 9'h1A5; bus.din = 32'hFFFFFFFF;
    rst = 1'b0;
    wait_ready(0, n);
    check("ready_low_cycles", 32'(n), 32'd512);

    for (int i = 0; i < 16; i++) req(vt[i].we, vt[i].wmask, vt[i].addr, vt[i].din, vt[i].exp);
    idle(4);

    // Read latency: valid only on the LAT-th sample after the accepting edge.
    bus.en = 1'b1; bus.we = 1'b0; bus.addr = 9'h1A5;
    sb.push_back(32'hDE22BE44);
    @(negedge clk);
    check("lat0", 32'(bus.dout_valid), 32'd0);
    @(posedge clk); #1;
    bus.en = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      check($sformatf("lat%0d", k), 32'(bus.dout_valid), 32'(k == LAT));
    end
    @(posedge clk); #1;

    for (int a = 0; a < 8; a++) req(1'b1, 4'hF, 9'(a), 32'(a), 32'h0);
    idle(4);
    max_run = 0;
    for (int a = 0; a < 8; a++) req(1'b0, 4'h0, 9'(a), 32'h0, 32'(a));
    idle(4);
    check("stream_run", 32'(max_run), 32'd8);

    req(1'b1, 4'hF, 9'h040, 32'h12345678, 32'h0);
    idle(4);
    prev = last_dat;
    req(1'b1, 4'h1, 9'h040, 32'h000000AB, 32'h0);
    idle(LAT + 2);
    check("wt_dout", bus.dout, WT ? 32'h123456AB : prev);
    req(1'b0, 4'h0, 9'h040, 32'h0, 32'h123456AB);
    idle(4);

    // Read issued together with a one-cycle reset pulse is dropped.
    bus.en = 1'b1; bus.we = 1'b0; bus.addr = 9'h1A5;
    rst = 1'b1;
    @(posedge clk); #1;
    bus.en = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    @(negedge clk);
    check("rst2_dout", bus.dout, 32'h0);
    check("rst2_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("rst2_ready", 32'(bus.ready), 32'd0);
    wait_ready(1, n);
    check("ready_low_after_rst", 32'(n), 32'd512);

    req(1'b0, 4'h0, 9'h1A5, 32'h0, 32'h0);
    req(1'b0, 4'h0, 9'h040, 32'h0, 32'h0);
    idle(4);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
